// File: rtl/fdiv_pkg.sv
// Shared types and width helpers for the sequential floating-point divider (fdiv_seq).
package fdiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } fdiv_state_e;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fdiv_class_t;

    // One quotient bit per weight 2^0 .. 2^-(FRAC_W+3): hidden + fraction + guard/round/extra.
    function automatic int q_bits(input int frac_w);
        return frac_w + 4;
    endfunction

    function automatic int cnt_bits(input int frac_w);
        return $clog2(frac_w + 4);
    endfunction

    function automatic logic [127:0] qnan_frac(input int frac_w);
        return 128'(1) << (frac_w - 1);
    endfunction

    localparam int DEF_FRAC_W = 23;
    localparam int DEF_Q      = q_bits(DEF_FRAC_W);
    localparam int DEF_CNT_W  = cnt_bits(DEF_FRAC_W);

endpackage

// File: rtl/fdiv_if.sv
// Operand/result bundle for fdiv_seq; master drives operands, slave is the divider.
// Handshake: a transfer happens on a rising edge where valid & ready are both high;
// valid must not depend on ready, and payload is held stable while valid is high.
interface fdiv_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    logic              in_valid;
    logic              in_ready;
    logic              a_sign;
    logic [EXP_W-1:0]  a_exp;
    logic [FRAC_W-1:0] a_frac;
    logic              b_sign;
    logic [EXP_W-1:0]  b_exp;
    logic [FRAC_W-1:0] b_frac;
    logic              out_valid;
    logic              out_ready;
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              invalid;
    logic              div_by_zero;
    logic              overflow;
    logic              underflow;

    modport master (
        output in_valid, a_sign, a_exp, a_frac, b_sign, b_exp, b_frac, out_ready,
        input  in_ready, out_valid, sign, exp, frac,
               invalid, div_by_zero, overflow, underflow
    );

    modport slave (
        input  in_valid, a_sign, a_exp, a_frac, b_sign, b_exp, b_frac, out_ready,
        output in_ready, out_valid, sign, exp, frac,
               invalid, div_by_zero, overflow, underflow
    );
endinterface

// File: rtl/fdiv_classify.sv
// Combinational operand classifier; subnormals (exp==0) are reported as zero.
module fdiv_classify
    import fdiv_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic [EXP_W-1:0]  exp,
    input  logic [FRAC_W-1:0] frac,
    output fdiv_class_t       cls
);
    logic exp_max;
    logic frac_nz;

    assign exp_max = &exp;
    assign frac_nz = |frac;

    always_comb begin
        cls.is_zero = (exp == '0);
        cls.is_inf  = exp_max & ~frac_nz;
        cls.is_nan  = exp_max & frac_nz;
    end
endmodule

// File: rtl/fdiv_seq.sv
// Iterative restoring floating-point divider with RNE rounding, DAZ/FTZ and IEEE flags.
// Define FDIV_RADIX4_EN to retire two quotient bits per DIV cycle.
module fdiv_seq
    import fdiv_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int BIAS   = 2**(EXP_W-1) - 1
) (
    input  logic        clk,
    input  logic        rst,
    fdiv_if.slave       bus,
    output fdiv_state_e state_dbg
);
    localparam int Q     = q_bits(FRAC_W);
    localparam int CNT_W = cnt_bits(FRAC_W);
    localparam int M_W   = FRAC_W + 1;
    localparam int R_W   = FRAC_W + 2;
    localparam int E_W   = EXP_W + 2;

    localparam logic [FRAC_W-1:0]    QNAN_FRAC = FRAC_W'(qnan_frac(FRAC_W));
    localparam logic [EXP_W-1:0]     EXP_MAX   = '1;
    localparam logic signed [E_W-1:0] BIAS_E   = E_W'(BIAS);
    localparam logic signed [E_W-1:0] E_OVF    = E_W'(2**EXP_W - 1);
    localparam logic [CNT_W-1:0]     CNT_INIT  = CNT_W'(Q - 1);

    fdiv_state_e state, state_nxt;

    fdiv_class_t ca, cb;

    logic                    accept;
    logic                    op_sign;
    logic signed [E_W-1:0]   e_base;
    logic [R_W-1:0]          rem, rem_nxt;
    logic [M_W-1:0]          mb;
    logic [Q-1:0]            quo, quo_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    div_last;

    logic                    r_sign, r_inv, r_dbz, r_ovf, r_unf;
    logic [EXP_W-1:0]        r_exp;
    logic [FRAC_W-1:0]       r_frac;

    logic                    is_special, sp_sign, sp_inv, sp_dbz;
    logic [EXP_W-1:0]        sp_exp;
    logic [FRAC_W-1:0]       sp_frac;

    fdiv_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_class_a (
        .exp (bus.a_exp),
        .frac(bus.a_frac),
        .cls (ca)
    );

    fdiv_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_class_b (
        .exp (bus.b_exp),
        .frac(bus.b_frac),
        .cls (cb)
    );

    assign accept    = bus.in_valid & bus.in_ready;
    assign state_dbg = state;

    // Special-case results are resolved at accept time and bypass the datapath.
    always_comb begin
        is_special = 1'b1;
        sp_sign    = bus.a_sign ^ bus.b_sign;
        sp_exp     = '0;
        sp_frac    = '0;
        sp_inv     = 1'b0;
        sp_dbz     = 1'b0;
        if (ca.is_nan | cb.is_nan) begin
            sp_sign = 1'b0;
            sp_exp  = EXP_MAX;
            sp_frac = QNAN_FRAC;
        end else if ((ca.is_zero & cb.is_zero) | (ca.is_inf & cb.is_inf)) begin
            sp_sign = 1'b0;
            sp_exp  = EXP_MAX;
            sp_frac = QNAN_FRAC;
            sp_inv  = 1'b1;
        end else if (ca.is_inf) begin
            sp_exp = EXP_MAX;
        end else if (cb.is_zero) begin
            sp_exp = EXP_MAX;
            sp_dbz = 1'b1;
        end else if (ca.is_zero | cb.is_inf) begin
            sp_exp = '0;
        end else begin
            is_special = 1'b0;
        end
    end

    // One restoring step: returns {quotient bit, next remainder already shifted left}.
    function automatic logic [R_W:0] div_step(input logic [R_W-1:0] r, input logic [M_W-1:0] d);
        logic [R_W-1:0] d_ext;
        logic [R_W-1:0] nr;
        logic           ge;
        d_ext = {1'b0, d};
        ge    = (r >= d_ext);
        nr    = (ge ? (r - d_ext) : r) << 1;
        return {ge, nr};
    endfunction

    logic [R_W:0] st1;
`ifdef FDIV_RADIX4_EN
    logic [R_W:0] st2;
`endif

    always_comb begin
        st1      = div_step(rem, mb);
        quo_nxt  = {quo[Q-2:0], st1[R_W]};
        rem_nxt  = st1[R_W-1:0];
        cnt_nxt  = cnt - CNT_W'(1);
        div_last = (cnt == '0);
`ifdef FDIV_RADIX4_EN
        st2 = div_step(st1[R_W-1:0], mb);
        // With an odd bit count the last cycle (cnt==0) retires only the single step.
        if (cnt != '0) begin
            quo_nxt = {quo[Q-3:0], st1[R_W], st2[R_W]};
            rem_nxt = st2[R_W-1:0];
            cnt_nxt = cnt - CNT_W'(2);
        end
        div_last = (cnt <= CNT_W'(1));
`endif
    end

    logic                  norm_shift, g_bit, r_bit, sticky, rnd_up, carry;
    logic [Q-1:0]          qn;
    logic [M_W-1:0]        mant;
    logic [M_W:0]          msum;
    logic [FRAC_W-1:0]     frac_n;
    logic signed [E_W-1:0] adj, e_fin;
    logic                  n_ovf, n_unf;

    always_comb begin
        norm_shift = ~quo[Q-1];
        qn         = norm_shift ? {quo[Q-2:0], 1'b0} : quo;
        mant       = qn[Q-1:3];
        g_bit      = qn[2];
        r_bit      = qn[1];
        sticky     = qn[0] | (rem != '0);
        rnd_up     = g_bit & (r_bit | sticky | mant[0]);
        msum       = {1'b0, mant} + (M_W+1)'(rnd_up);
        carry      = msum[M_W];
        frac_n     = carry ? msum[M_W-1:1] : msum[M_W-2:0];
        adj        = $signed({{(E_W-1){1'b0}}, carry}) - $signed({{(E_W-1){1'b0}}, norm_shift});
        e_fin      = e_base + adj;
        n_ovf      = (e_fin >= E_OVF);
        n_unf      = e_fin[E_W-1] | (e_fin == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = is_special ? S_DONE : S_DIV;
            end
            S_DIV:  if (div_last) state_nxt = S_NORM;
            S_NORM: state_nxt = S_DONE;
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_sign <= 1'b0;
            e_base  <= '0;
            rem     <= '0;
            mb      <= '0;
            quo     <= '0;
            cnt     <= '0;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_frac  <= '0;
            r_inv   <= 1'b0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_sign <= bus.a_sign ^ bus.b_sign;
                    e_base  <= $signed({2'b00, bus.a_exp}) - $signed({2'b00, bus.b_exp}) + BIAS_E;
                    rem     <= {2'b01, bus.a_frac};
                    mb      <= {1'b1, bus.b_frac};
                    quo     <= '0;
                    cnt     <= CNT_INIT;
                    if (is_special) begin
                        r_sign <= sp_sign;
                        r_exp  <= sp_exp;
                        r_frac <= sp_frac;
                        r_inv  <= sp_inv;
                        r_dbz  <= sp_dbz;
                    end
                end
                S_DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt_nxt;
                end
                S_NORM: begin
                    r_sign <= op_sign;
                    if (n_ovf) begin
                        r_exp  <= EXP_MAX;
                        r_frac <= '0;
                        r_ovf  <= 1'b1;
                    end else if (n_unf) begin
                        r_exp  <= '0;
                        r_frac <= '0;
                        r_unf  <= 1'b1;
                    end else begin
                        r_exp  <= e_fin[EXP_W-1:0];
                        r_frac <= frac_n;
                    end
                end
                S_DONE: if (bus.out_ready) begin
                    r_sign <= 1'b0;
                    r_exp  <= '0;
                    r_frac <= '0;
                    r_inv  <= 1'b0;
                    r_dbz  <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_unf  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.sign        = r_sign;
    assign bus.exp         = r_exp;
    assign bus.frac        = r_frac;
    assign bus.invalid     = r_inv;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf;
    assign bus.underflow   = r_unf;

endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: vector table plus backpressure and reset-abort sequences.
module tb_fdiv_seq;
    import fdiv_pkg::*;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int W      = 36;
    localparam int QB     = FRAC_W + 4;
`ifdef FDIV_RADIX4_EN
    localparam int LAT_DIV = (QB + 1) / 2 + 2;
`else
    localparam int LAT_DIV = QB + 2;
`endif
    localparam int LAT_SP  = 1;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_INV  = 4'b1000;
    localparam logic [3:0] F_DBZ  = 4'b0100;
    localparam logic [3:0] F_OVF  = 4'b0010;
    localparam logic [3:0] F_UNF  = 4'b0001;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    fdiv_state_e state_dbg;

    fdiv_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) bus ();

    fdiv_seq #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    int           n_checks = 0;
    int           n_pass   = 0;
    string        cur_name = "reset";

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    function automatic logic [W-1:0] dut_word();
        return {bus.sign, bus.exp, bus.frac,
                bus.invalid, bus.div_by_zero, bus.overflow, bus.underflow};
    endfunction

    // Scoreboard: every result handed off is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result %s: got %0h expected none", cur_name, dut_word());
            end else begin
                mon_exp = exp_q.pop_front();
                check({"result ", cur_name}, 64'(dut_word()), 64'(mon_exp));
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #2;
            guard++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            $display("FAIL in_ready_timeout %s: got 0 expected 1", cur_name);
        end
        bus.a_sign   = a[31];
        bus.a_exp    = a[30:23];
        bus.a_frac   = a[22:0];
        bus.b_sign   = b[31];
        bus.b_exp    = b[30:23];
        bus.b_frac   = b[22:0];
        bus.in_valid = 1'b1;
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 200);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        cur_name = v.name;
        exp_q.push_back({v.res, v.flags});
        send(v.a, v.b);
        wait_out(lat);
        check({"latency ", v.name}, 64'(lat), 64'(v.lat));
        @(posedge clk); #2;
        check({"flags_cleared ", v.name},
              64'({bus.invalid, bus.div_by_zero, bus.overflow, bus.underflow}), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   lat;
        int   spurious;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a_sign    = 1'b0;
        bus.a_exp     = '0;
        bus.a_frac    = '0;
        bus.b_sign    = 1'b0;
        bus.b_exp     = '0;
        bus.b_frac    = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(bus.in_ready), 64'(1));
        check("reset_out_valid", 64'(bus.out_valid), 64'(0));
        check("reset_outputs", 64'(dut_word()), 64'(0));
        check("reset_state", 64'(state_dbg), 64'(S_IDLE));
        @(posedge clk); #2;

        vecs.push_back('{"div6_2",      32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, LAT_DIV});
        vecs.push_back('{"div1_3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAB, F_NONE, LAT_DIV});
        vecs.push_back('{"div1_1",      32'h3F800000, 32'h3F800000, 32'h3F800000, F_NONE, LAT_DIV});
        vecs.push_back('{"div1p5_1p25", 32'h3FC00000, 32'h3FA00000, 32'h3F99999A, F_NONE, LAT_DIV});
        vecs.push_back('{"neg6_2",      32'hC0C00000, 32'h40000000, 32'hC0400000, F_NONE, LAT_DIV});
        vecs.push_back('{"zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, F_INV,  LAT_SP});
        vecs.push_back('{"one_zero",    32'h3F800000, 32'h00000000, 32'h7F800000, F_DBZ,  LAT_SP});
        vecs.push_back('{"negone_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, F_DBZ,  LAT_SP});
        vecs.push_back('{"inf_inf",     32'h7F800000, 32'hFF800000, 32'h7FC00000, F_INV,  LAT_SP});
        vecs.push_back('{"nan_one",     32'h7FC00001, 32'hBF800000, 32'h7FC00000, F_NONE, LAT_SP});
        vecs.push_back('{"ninf_two",    32'hFF800000, 32'h40000000, 32'hFF800000, F_NONE, LAT_SP});
        vecs.push_back('{"inf_zero",    32'h7F800000, 32'h00000000, 32'h7F800000, F_NONE, LAT_SP});
        vecs.push_back('{"two_inf",     32'h40000000, 32'h7F800000, 32'h00000000, F_NONE, LAT_SP});
        vecs.push_back('{"nzero_five",  32'h80000000, 32'h40A00000, 32'h80000000, F_NONE, LAT_SP});
        vecs.push_back('{"daz_subnorm", 32'h00000001, 32'h3F800000, 32'h00000000, F_NONE, LAT_SP});
        vecs.push_back('{"ovf_basic",   32'h7F000000, 32'h3E800000, 32'h7F800000, F_OVF,  LAT_DIV});
        vecs.push_back('{"max_finite",  32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, F_NONE, LAT_DIV});
        vecs.push_back('{"ovf_edge",    32'h7F7FFFFF, 32'h3F7FFFFF, 32'h7F800000, F_OVF,  LAT_DIV});
        vecs.push_back('{"unf_basic",   32'h00800000, 32'h40000000, 32'h00000000, F_UNF,  LAT_DIV});
        vecs.push_back('{"min_normal",  32'h00800000, 32'h3F800000, 32'h00800000, F_NONE, LAT_DIV});
        vecs.push_back('{"unf_shift",   32'h00800000, 32'h3F800001, 32'h00000000, F_UNF,  LAT_DIV});

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result held for 5 cycles with out_ready low.
        cur_name      = "backpressure";
        bus.out_ready = 1'b0;
        exp_q.push_back({32'h40400000, F_NONE});
        send(32'h40C00000, 32'h40000000);
        wait_out(lat);
        check("bp_latency", 64'(lat), 64'(LAT_DIV));
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 64'(bus.out_valid), 64'(1));
            check("bp_hold_result", 64'(dut_word()), 64'({32'h40400000, F_NONE}));
            check("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
            @(negedge clk);
        end
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_handoff_in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #2;
        check("bp_after_out_valid", 64'(bus.out_valid), 64'(0));
        check("bp_after_in_ready", 64'(bus.in_ready), 64'(1));

        // Reset in the middle of DIV aborts with no result.
        cur_name = "reset_abort";
        send(32'h40C00000, 32'h40000000);
        repeat (9) begin
            @(posedge clk); #2;
        end
        check("abort_in_div", 64'(state_dbg), 64'(S_DIV));
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check("abort_out_valid", 64'(bus.out_valid), 64'(0));
        check("abort_in_ready", 64'(bus.in_ready), 64'(1));
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) spurious++;
        end
        check("abort_no_result", 64'(spurious), 64'(0));
        @(posedge clk); #2;
        run_vec('{"after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, LAT_DIV});

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
